// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one uart_tx between
// NUM_REQ byte-stream requesters. Once a requester is granted, the grant
// stays locked for its whole packet (up to req_last). If the requester
// goes quiet mid-packet for HOLD_TIMEOUT cycles, the lock is dropped.
module uart_tx_arbiter #(
  parameter  int NUM_REQ      = 4,
  parameter  int HOLD_TIMEOUT = 1024,
  localparam int IDW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNTW         = $clog2(HOLD_TIMEOUT + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [8*NUM_REQ-1:0]   i_req_data,
  input  logic [NUM_REQ-1:0]     i_req_last,
  output logic [NUM_REQ-1:0]     o_req_ready,
  output logic                   o_grant_valid,
  output logic [IDW-1:0]         o_grant_id,
  output logic                   o_lock_timeout,
  output logic                   o_uart_start,
  output logic [7:0]             o_uart_data,
  input  logic                   i_uart_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_LOCKED
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [IDW-1:0]  r_grant_id;
  logic [IDW-1:0]  r_rr_ptr;
  logic            r_pkt_last;
  logic            r_in_pkt;
  logic [CNTW-1:0] r_hold_cnt;

  logic            w_any_valid;
  logic [IDW-1:0]  w_sel_id;
  logic            w_cur_valid;
  logic            w_cur_last;
  logic [7:0]      w_cur_data;
  logic            w_issue;
  logic            w_timeout;
  logic            w_release;
  logic [IDW-1:0]  w_rr_next;

  // Signals of the currently granted requester.
  assign w_cur_valid = i_req_valid[r_grant_id];
  assign w_cur_last  = i_req_last[r_grant_id];
  assign w_cur_data  = i_req_data[{r_grant_id, 3'b000} +: 8];

  // A byte is handed to uart_tx only when the owner has data and the UART is free.
  assign w_issue   = (r_state == S_ISSUE) && w_cur_valid && !i_uart_busy;
  assign w_timeout = (r_state == S_LOCKED) && !w_cur_valid &&
                     (r_hold_cnt == CNTW'(HOLD_TIMEOUT));
  assign w_release = ((r_state == S_WAIT_DONE) && !i_uart_busy && r_pkt_last) ||
                     w_timeout;
  assign w_rr_next = (r_grant_id == IDW'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;

  // Round-robin pick: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    logic [IDW-1:0] v_idx;
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would otherwise infer a latch.
    w_any_valid = 1'b0;
    w_sel_id    = '0;
    v_idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      v_idx = IDW'((int'(r_rr_ptr) + i) % NUM_REQ);
      if (!w_any_valid && i_req_valid[v_idx]) begin
        w_any_valid = 1'b1;
        w_sel_id    = v_idx;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:      if (w_any_valid) w_next_state = S_ISSUE;
      S_ISSUE: begin
        if (!w_cur_valid)      w_next_state = r_in_pkt ? S_LOCKED : S_IDLE;
        else if (!i_uart_busy) w_next_state = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: if (i_uart_busy) w_next_state = S_WAIT_DONE;
      S_WAIT_DONE: if (!i_uart_busy) w_next_state = r_pkt_last ? S_IDLE : S_LOCKED;
      S_LOCKED: begin
        if (w_cur_valid)    w_next_state = S_ISSUE;
        else if (w_timeout) w_next_state = S_IDLE;
      end
      default:     w_next_state = S_IDLE;
    endcase
  end

  // Grant bookkeeping: owner id, round-robin pointer, packet tracking, hold timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      r_pkt_last <= 1'b0;
      r_in_pkt   <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_any_valid) r_grant_id <= w_sel_id;
      if (w_issue) begin
        r_pkt_last <= w_cur_last;
        r_in_pkt   <= !w_cur_last;
      end
      if (w_release) begin
        r_rr_ptr <= w_rr_next;
        r_in_pkt <= 1'b0;
      end
      // The timer only runs while the owner is silent inside a locked packet.
      if ((r_state == S_LOCKED) && !w_cur_valid && !w_timeout)
        r_hold_cnt <= r_hold_cnt + 1'b1;
      else
        r_hold_cnt <= '0;
    end
  end

  // Outputs: the UART strobe, data and the one-hot accept share one cycle.
  always_comb begin
    o_req_ready             = '0;
    o_req_ready[r_grant_id] = w_issue;
    o_uart_start            = w_issue;
    o_uart_data             = w_issue ? w_cur_data : 8'h00;
    o_grant_valid           = (r_state != S_IDLE);
    o_grant_id              = r_grant_id;
    o_lock_timeout          = w_timeout;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares a single `uart_tx` transmitter between `NUM_REQ` byte-stream requesters. Each requester presents bytes with a valid/ready handshake and a `last` flag marking the end of a packet. The arbiter locks the grant to one requester for a whole packet, so bytes from different requesters never interleave on the wire. It sits between client logic and `uart_tx`, driving its `start`/`data` pins and observing its `busy` output.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `HOLD_TIMEOUT`, 1024: cycles a locked requester may leave `req_valid` low mid-packet before the lock is forcibly released; ≥1.
- `clk` in 1: system clock.
- `rst` in 1: reset. One clock; reset is asynchronous and active-high.
- `req_valid` in NUM_REQ: per-requester byte available.
- `req_data` in 8·NUM_REQ: byte for requester i in `[8i+7:8i]`.
- `req_last` in NUM_REQ: byte is the final byte of its packet.
- `req_ready` out NUM_REQ: one-hot accept pulse; the byte is consumed in the cycle this bit is high.
- `grant_valid` out 1: a requester currently owns the transmitter.
- `grant_id` out max(1,$clog2(NUM_REQ)): index of the owning requester.
- `lock_timeout` out 1: one-cycle pulse when a lock is released by timeout.
- `uart_start` out 1: to `uart_tx.start`.
- `uart_data` out 8: to `uart_tx.data`.
- `uart_busy` in 1: from `uart_tx.busy`.

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, LOCKED.
- IDLE:
  - If any `req_valid` is high, select the first valid index scanning upward from `rr_ptr`, wrapping modulo NUM_REQ.
  - Register it into `grant_id`, set `grant_valid`, go to ISSUE.
- ISSUE:
  - If `req_valid[grant_id]` is high and `uart_busy` is low, drive `uart_start`=1, `uart_data`=`req_data[grant_id]` and `req_ready[grant_id]`=1 combinationally, all for exactly this one cycle.
  - Latch `req_last[grant_id]` into `pkt_last`, then go to WAIT_BUSY.
  - If `uart_busy` is high, stay in ISSUE with all outputs low.
  - If `req_valid[grant_id]` is low, go to LOCKED when inside a packet, otherwise go to IDLE and clear `grant_valid`.
- WAIT_BUSY: go to WAIT_DONE on `uart_busy`=1.
- WAIT_DONE, on `uart_busy`=0:
  - If `pkt_last` is set, release: go to IDLE, clear `grant_valid`, set `rr_ptr`=(`grant_id`+1) mod NUM_REQ.
  - Otherwise go to LOCKED.
- LOCKED:
  - If `req_valid[grant_id]` is high, go to ISSUE and clear the hold counter.
  - Otherwise increment the hold counter. When it reaches HOLD_TIMEOUT, pulse `lock_timeout`, release exactly as on `last`, and go to IDLE.
- Other requesters' valid signals are ignored while a grant is held. A packet of any length may hold the transmitter.
- Requesters must hold data and last stable while valid is high until ready. Dropping valid mid-packet is legal and is covered by the timeout.

## Timing
- Reset values:
  - state IDLE, `rr_ptr`=0, hold counter 0.
  - `req_ready`=0, `grant_valid`=0, `grant_id`=0, `lock_timeout`=0, `uart_start`=0, `uart_data`=0.
- Arbitration latency: `req_valid` high in cycle n while IDLE gives `grant_valid` high and ISSUE in n+1. `uart_start` and `req_ready` also fire in n+1 if `uart_busy` is low.
- `uart_start` is never high for two consecutive cycles, and is never high while `uart_busy` is high.
- `uart_tx` raises `busy` one cycle after `start`. WAIT_BUSY therefore normally lasts one cycle.
- Back-to-back bytes in a locked packet: `uart_busy` falls in cycle m, giving LOCKED in m+1 and ISSUE/`uart_start` in m+2.
- Release to the next grant: IDLE in m+1, the new grant in m+2, `uart_start` in m+2.
- Simultaneous requests in IDLE: the lowest index at or above `rr_ptr` wins; the wrap from index NUM_REQ-1 goes to 0.
- Timeout: `lock_timeout` pulses in the cycle the hold counter equals HOLD_TIMEOUT, which is the HOLD_TIMEOUT+1-th consecutive LOCKED cycle with valid low. IDLE follows in the next cycle.
- Reset mid-transfer forces IDLE immediately and all outputs low; any partial packet is abandoned.

## Test plan
- Single requester: req0 sends 3 bytes 0xA5, 0x5A, 0xFF with last on the third. Required: exactly 3 `uart_start` pulses with matching `uart_data`, 3 `req_ready[0]` pulses, and `grant_valid` falling after the third `busy` falls.
- Contention: all 4 requesters hold 1-byte packets from reset. Required: grant order 0,1,2,3, then 0 again if re-requested, with `rr_ptr` wrapping correctly.
- Packet lock: req1 sends a 4-byte packet while req0 and req2 are valid throughout. Required: no `req_ready` to req0 or req2 until req1's last byte completes, then req2 is granted.
- Lock timeout, with HOLD_TIMEOUT=8: req3 sends 1 non-last byte, then drops valid. Required: `lock_timeout` pulses 9 cycles after entering LOCKED, and a pending req0 is granted 2 cycles later.
- Busy stall: hold `uart_busy`=1 externally while ISSUE is active. Required: `uart_start`=0 and `req_ready`=0 until `busy` is low, then a single pulse.
- Reset in WAIT_DONE: assert `rst` asynchronously mid-frame. Required: all outputs 0 in the same cycle, and `rr_ptr`=0 afterwards.
